vdp_cpu_bus: RTL and testbench

- Upstream CPU-side front end of the vdp99 VRAM/register block.
- Takes the asynchronous Z8S180 VDP chip-selects (read and write strobes), the MODE address bit and the data bus.
- Produces single-clk rd_tick/wr_tick pulses with a stable mode/din, as the vram block consumes them.
- Returns vram dout to the CPU with read-ahead semantics: data is captured at strobe start and the rd_tick advance fires at strobe end.

---
 rtl/vdp99_pkg.sv | 41 ++++
 rtl/vdp_strobe_sync.sv | 119 +++++++++++
 rtl/vdp_cpu_bus.sv | 117 +++++++++++
 tb/tb_vdp_cpu_bus.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vdp99_pkg.sv
// vdp99_pkg: shared constants and types for the vdp99 CPU-side front end.
//   MODE_DATA / MODE_REG  : meaning of the CPU MODE address bit
//   SYNC_STAGES_DEF       : default synchronizer depth (min 2)
//   MIN_LOW_DEF           : default glitch-filter length in clk samples (min 1)
//   strb_st_e             : per-strobe FSM state encoding
//   cpu_wr_t              : {mode, data} word carried alongside each strobe
package vdp99_pkg;

  localparam logic MODE_DATA = 1'b0;
  localparam logic MODE_REG  = 1'b1;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int MIN_LOW_DEF     = 2;

  // Lane 0 = read strobe (csr), lane 1 = write strobe (csw).
  localparam int NUM_LANES = 2;
  localparam int LANE_RD   = 0;
  localparam int LANE_WR   = 1;

  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,  // waiting for the bus to be seen idle (high)
    ST_IDLE   = 2'd1,  // high and armed
    ST_QUAL   = 2'd2,  // low, counting consecutive low samples
    ST_ACTIVE = 2'd3   // low and accepted
  } strb_st_e;

  typedef struct packed {
    logic       mode;
    logic [7:0] data;
  } cpu_wr_t;

  localparam int VEC_W = $bits(cpu_wr_t);

  // 8-bit saturating accumulate (sticks at 8'hFF).
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/vdp_strobe_sync.sv
// vdp_strobe_sync: one CPU strobe lane.
// Synchronizes an asynchronous active-low strobe plus the data word that
// travels with it, filters short low glitches and tracks the strobe through
// ARM/IDLE/QUAL/ACTIVE.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   strb_n       raw asynchronous strobe (active low)
//   data         raw asynchronous {mode, data} word
//   all_high     every lane's synchronized strobe is high (re-arm condition)
//   abort        collision: drop to ARM without an end event
//   level        synchronized strobe level
//   active       FSM is in ACTIVE
//   end_pulse    comb., ACTIVE strobe seen high this cycle (strobe end)
//   glitch       comb., low run shorter than MIN_LOW rejected this cycle
//   data_lat     data word captured on the last low sample of the strobe
module vdp_strobe_sync
  import vdp99_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MIN_LOW     = MIN_LOW_DEF,
  parameter int DW          = VEC_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          strb_n,
  input  logic [DW-1:0] data,
  input  logic          all_high,
  input  logic          abort,
  output logic          level,
  output logic          active,
  output logic          end_pulse,
  output logic          glitch,
  output logic [DW-1:0] data_lat
);

  localparam int CW = $clog2(MIN_LOW + 1);

  logic [SYNC_STAGES-1:0]         strb_sync;
  logic [SYNC_STAGES-1:0][DW-1:0] data_sync;
  // Fills with ones after reset; the synchronizer output only reflects the
  // real pin once this is full, so a strobe held low across reset release
  // cannot be mistaken for an idle-high bus.
  logic [SYNC_STAGES-1:0]         vld_pipe;
  logic                           primed;
  logic [DW-1:0]                  sdata;
  strb_st_e                       state, state_nxt;
  logic [CW-1:0]                  cnt, cnt_nxt;

  assign level  = strb_sync[SYNC_STAGES-1];
  assign sdata  = data_sync[SYNC_STAGES-1];
  assign primed = vld_pipe[SYNC_STAGES-1];
  assign active = (state == ST_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_sync <= '1;
      data_sync <= '0;
      vld_pipe  <= '0;
    end else begin
      strb_sync <= {strb_sync[SYNC_STAGES-2:0], strb_n};
      data_sync <= {data_sync[SYNC_STAGES-2:0], data};
      vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    end_pulse = 1'b0;
    glitch    = 1'b0;
    if (abort) begin
      state_nxt = ST_ARM;
    end else begin
      unique case (state)
        ST_ARM: begin
          if (primed && all_high) state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (!level) begin
            cnt_nxt   = CW'(1);
            state_nxt = (MIN_LOW <= 1) ? ST_ACTIVE : ST_QUAL;
          end
        end
        ST_QUAL: begin
          if (level) begin
            state_nxt = ST_IDLE;
            glitch    = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
            if (cnt_nxt == CW'(MIN_LOW)) state_nxt = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (level) begin
            state_nxt = ST_IDLE;
            end_pulse = 1'b1;
          end
        end
        default: state_nxt = ST_ARM;
      endcase
    end
  end

  // Data is refreshed on every low sample of an armed strobe, so the value
  // held at the end event is the one from the final low sample. A strobe of
  // exactly MIN_LOW samples never has a low sample in ACTIVE itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ARM;
      cnt      <= '0;
      data_lat <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!level && state != ST_ARM && !abort) data_lat <= sdata;
    end
  end

endmodule

// File: rtl/vdp_cpu_bus.sv
// vdp_cpu_bus: CPU-side front end of the vdp99 VRAM/register block.
// Turns the asynchronous Z8S180 VDP read/write chip-selects into single-clk
// rd_tick / wr_tick pulses with stable mode/din, and returns vram read data
// with read-ahead semantics (captured at strobe start, advanced at strobe end).
// Optional build macro: VDP_CPU_BUS_ERR_CNT_EN adds bus_err_cnt.
// Ports:
//   clk, reset          pixel clock, async active-low reset
//   cpu_csr_n/cpu_csw_n async read/write strobes (active low)
//   cpu_mode, cpu_din   CPU MODE bit and write data
//   cpu_dout, cpu_doe   read data and data-bus output enable to the CPU
//   vdp_dout            vram read data (prefetch byte or status)
//   wr_tick, rd_tick    one-clk pulses to vram
//   mode, din           qualifiers valid with the ticks
//   bus_err_cnt         (optional) saturating collision + glitch count
module vdp_cpu_bus
  import vdp99_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MIN_LOW     = MIN_LOW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_csr_n,
  input  logic       cpu_csw_n,
  input  logic       cpu_mode,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_doe,
  input  logic [7:0] vdp_dout,
  output logic       wr_tick,
  output logic       rd_tick,
  output logic       mode,
  output logic [7:0] din
`ifdef VDP_CPU_BUS_ERR_CNT_EN
  ,
  output logic [7:0] bus_err_cnt
`endif
);

  logic    [NUM_LANES-1:0] strb_n, level, active, end_pulse, glitch;
  cpu_wr_t [NUM_LANES-1:0] lat;
  cpu_wr_t                 cpu_req;
  logic                    abort, all_high;

  assign strb_n   = {cpu_csw_n, cpu_csr_n};
  assign cpu_req  = {cpu_mode, cpu_din};
  // Both strobes accepted at once is a bus error: both lanes drop to ARM.
  assign abort    = &active;
  // Lanes re-arm only once the whole bus has been seen idle.
  assign all_high = &level;

  // Output enable follows the raw pin so the CPU sees data immediately.
  assign cpu_doe  = ~cpu_csr_n & reset;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vdp_strobe_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .MIN_LOW    (MIN_LOW),
      .DW         (VEC_W)
    ) u_sync (
      .clk      (clk),
      .rst_n    (reset),
      .strb_n   (strb_n[i]),
      .data     (cpu_req),
      .all_high (all_high),
      .abort    (abort),
      .level    (level[i]),
      .active   (active[i]),
      .end_pulse(end_pulse[i]),
      .glitch   (glitch[i]),
      .data_lat (lat[i])
    );
  end

  // end_pulse lanes are mutually exclusive: an end needs ACTIVE, and both
  // lanes ACTIVE together is aborted, so ticks never coincide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_tick  <= 1'b0;
      rd_tick  <= 1'b0;
      mode     <= MODE_DATA;
      din      <= '0;
      cpu_dout <= '0;
    end else begin
      wr_tick <= end_pulse[LANE_WR];
      rd_tick <= end_pulse[LANE_RD];
      if (end_pulse[LANE_WR]) begin
        mode <= lat[LANE_WR].mode;
        din  <= lat[LANE_WR].data;
      end else if (end_pulse[LANE_RD]) begin
        mode <= lat[LANE_RD].mode;
      end
      // Read-ahead: track vram until the read is accepted, then hold.
      if (!active[LANE_RD]) cpu_dout <= vdp_dout;
    end
  end

  // The read lane carries the data word only for its mode bit.
  logic rd_data_unused;
  assign rd_data_unused = ^lat[LANE_RD].data;

`ifdef VDP_CPU_BUS_ERR_CNT_EN
  logic [1:0] err_inc;
  // A collision and a glitch cannot hit the same lane in one cycle, and a
  // collision needs both lanes ACTIVE, so at most two events per cycle.
  assign err_inc = {1'b0, glitch[LANE_RD]} + {1'b0, glitch[LANE_WR]} + {1'b0, abort};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus_err_cnt <= '0;
    else        bus_err_cnt <= sat_add8(bus_err_cnt, err_inc);
  end
`else
  logic glitch_unused;
  assign glitch_unused = ^glitch;
`endif

endmodule

// File: tb/tb_vdp_cpu_bus.sv
// tb_vdp_cpu_bus: scoreboard bench for vdp_cpu_bus.
// The driver issues whole CPU strobes and, from the strobe length and bus
// state, predicts whether a tick must appear, with which mode/data and on
// which clk; a separate monitor pops and compares whenever a tick shows up.
module tb_vdp_cpu_bus;

  localparam int S  = 2;
  localparam int ML = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_csr_n, cpu_csw_n, cpu_mode;
  logic [7:0] cpu_din, cpu_dout, vdp_dout, din;
  logic       cpu_doe, wr_tick, rd_tick, mode;
`ifdef VDP_CPU_BUS_ERR_CNT_EN
  logic [7:0] bus_err_cnt;
`endif

  always #5 clk = ~clk;

  vdp_cpu_bus #(.SYNC_STAGES(S), .MIN_LOW(ML)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_csr_n(cpu_csr_n),
    .cpu_csw_n(cpu_csw_n),
    .cpu_mode (cpu_mode),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_doe  (cpu_doe),
    .vdp_dout (vdp_dout),
    .wr_tick  (wr_tick),
    .rd_tick  (rd_tick),
    .mode     (mode),
    .din      (din)
`ifdef VDP_CPU_BUS_ERR_CNT_EN
    ,
    .bus_err_cnt(bus_err_cnt)
`endif
  );

  typedef struct {
    bit         is_wr;
    bit         mode;
    logic [7:0] din;
    logic [7:0] dout;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0;
  int   err_model = 0;
  bit   armed = 1'b1;   // bus has been seen idle since the last error/reset
  bit   prev_tick = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tick must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (wr_tick || rd_tick) begin
        chk("tick_spacing", {31'b0, prev_tick}, 0);
        chk("tick_exclusive", {31'b0, wr_tick & rd_tick}, 0);
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_tick: got wr=%0b rd=%0b din=%0h, expected no tick (cycle %0d)",
                   wr_tick, rd_tick, din, cyc);
        end else begin
          e = q.pop_front();
          chk("tick_kind", {31'b0, wr_tick}, {31'b0, e.is_wr});
          chk("tick_mode", {31'b0, mode}, {31'b0, e.mode});
          chk("tick_cycle", cyc, e.cyc);
          if (e.is_wr) chk("wr_din", {24'b0, din}, {24'b0, e.din});
          else         chk("rd_dout", {24'b0, cpu_dout}, {24'b0, e.dout});
        end
      end
      prev_tick = wr_tick | rd_tick;
    end else begin
      prev_tick = 1'b0;
    end
  end

  // One complete strobe: low for len clks, then high for gap clks.
  // A read presents v0 on vdp_dout at strobe start and v1 from its 4th clk.
  task automatic strobe(input bit is_wr, input bit m, input logic [7:0] d,
                        input int len, input int gap,
                        input logic [7:0] v0, input logic [7:0] v1);
    @(posedge clk); #1;
    cpu_mode = m;
    cpu_din  = d;
    if (is_wr) cpu_csw_n = 1'b0;
    else begin
      cpu_csr_n = 1'b0;
      vdp_dout  = v0;
    end
    for (int i = 1; i < len; i++) begin
      @(posedge clk); #1;
      if (!is_wr) chk("doe_during_read", {31'b0, cpu_doe}, 1);
      if (!is_wr && armed && i >= 4) chk("rd_dout_frozen", {24'b0, cpu_dout}, {24'b0, v0});
      if (!is_wr && i == 4) vdp_dout = v1;
    end
    @(posedge clk); #1;
    cpu_csw_n = 1'b1;
    cpu_csr_n = 1'b1;
    // Scramble the data lines on release: the tick must carry the held value.
    cpu_mode  = 1'($urandom);
    cpu_din   = 8'($urandom);
    if (armed && len >= ML) q.push_back('{is_wr, m, d, v0, cyc + S + 1});
    else if (armed) err_model++;
    repeat (gap - 1) @(posedge clk);
  endtask

  task automatic settle(input string tag);
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_pending_ticks"}, q.size(), 0);
`ifdef VDP_CPU_BUS_ERR_CNT_EN
    chk({tag, "_err_cnt"}, {24'b0, bus_err_cnt}, (err_model > 255) ? 255 : err_model);
`endif
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    cpu_csr_n = 1'b1;
    cpu_csw_n = 1'b1;
    cpu_mode  = 1'b0;
    cpu_din   = 8'h00;
    vdp_dout  = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_tick", {31'b0, wr_tick}, 0);
    chk("rst_rd_tick", {31'b0, rd_tick}, 0);
    chk("rst_mode", {31'b0, mode}, 0);
    chk("rst_din", {24'b0, din}, 0);
    chk("rst_cpu_dout", {24'b0, cpu_dout}, 0);
    chk("rst_cpu_doe", {31'b0, cpu_doe}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    settle("init");

    // Two register writes, 6 clks low each.
    strobe(1'b1, 1'b1, 8'h00, 6, 3, 8'h00, 8'h00);
    strobe(1'b1, 1'b1, 8'h40, 6, 3, 8'h00, 8'h00);
    settle("writes");

    // Read-ahead: vram data changes mid-strobe, CPU keeps the first value.
    strobe(1'b0, 1'b0, 8'h00, 6, 3, 8'hA5, 8'h3C);
    settle("read");

    // One-clk write glitch: rejected.
    strobe(1'b1, 1'b0, 8'hEE, 1, 3, 8'h00, 8'h00);
    settle("glitch");

    // Collision, then single re-assertions while the bus is not idle.
    @(posedge clk); #1;
    cpu_csr_n = 1'b0;
    cpu_csw_n = 1'b0;
    cpu_din   = 8'h99;
    repeat (5) @(posedge clk); #1;
    cpu_csr_n = 1'b1;
    err_model++;
    armed = 1'b0;
    repeat (3) @(posedge clk); #1;
    cpu_csr_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    cpu_csr_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    cpu_csw_n = 1'b1;
    armed = 1'b1;
    repeat (4) @(posedge clk);
    strobe(1'b1, 1'b0, 8'h11, 4, 3, 8'h00, 8'h00);
    settle("collision");

    // Reset during a write, released with the strobe still low.
    @(posedge clk); #1;
    cpu_csw_n = 1'b0;
    cpu_mode  = 1'b1;
    cpu_din   = 8'h77;
    repeat (5) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_cpu_dout", {24'b0, cpu_dout}, 0);
    chk("midrst_din", {24'b0, din}, 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    err_model = 0;
    repeat (3) @(posedge clk); #1;
    cpu_csw_n = 1'b1;
    repeat (6) @(posedge clk);
    strobe(1'b1, 1'b0, 8'h33, 4, 3, 8'h00, 8'h00);
    settle("reset_mid");

    // Back-to-back writes 00..0F.
    for (int b = 0; b < 16; b++)
      strobe(1'b1, 1'($urandom), 8'(b), 4, 3, 8'h00, 8'h00);
    settle("burst");

    // Random mix of reads, writes and glitches.
    for (int n = 0; n < 60; n++)
      strobe(1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(1, 6),
             $urandom_range(1, 4), 8'($urandom), 8'($urandom));
    settle("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
